axis_rr_write_arbiter: RTL and testbench
========================================

Name: axis_rr_write_arbiter

Overview:
- Shares one AXI4-Stream write path (for example, the stream fed to an AXI-to-stream writer or a DMA/FIFO sink) among NUM_PORTS stream requesters.
- Round-robin arbitration with packet locking: a grant holds until the granted port's tlast, or until a programmable beat limit is reached.
- Single registered output stage.
- Reports the source port index and grant status alongside the data.

Parameters:
- NUM_PORTS, 4: number of slave requesters; legal range 2..8.
- ID_WIDTH, 2: width of the port index; must satisfy 2**ID_WIDTH >= NUM_PORTS.
- AXIS_TDATA_WIDTH, 32: data width per port.
- MAX_BEATS, 0: forced-release beat limit; 0 means unlimited (release on tlast only); legal range 0..65535.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*AXIS_TDATA_WIDTH  port k occupies bits [k*W +: W].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tready  out  NUM_PORTS  per-port ready; one-hot or zero.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  registered output data.
- m_axis_tid  out  ID_WIDTH  source port of the current output beat.
- m_axis_tlast  out  1  output tlast; see the forced-release rule.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- sts_busy  out  1  high while a grant is held (state LOCKED).
- sts_grant  out  ID_WIDTH  currently or most recently granted port.

Behaviour:
- Reset (asynchronous assert, synchronous release on aclk):
  - state=IDLE; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tid=0; m_axis_tlast=0.
  - sts_busy=0; sts_grant=0; last-served pointer = NUM_PORTS-1, so port 0 has first priority; beat counter=0.
- State IDLE:
  - All s_axis_tready=0.
  - If any tvalid is high, select the first valid port searching from last+1 upward, modulo NUM_PORTS.
  - Register the selection into grant and go to LOCKED on the next edge. Arbitration costs exactly 1 cycle.
  - With no tvalid, stay in IDLE.
- State LOCKED:
  - s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready. All other ready bits are 0.
  - A beat is accepted when tvalid[grant] & tready[grant]. On acceptance: capture tdata, tlast and tid=grant into the output register, set m_axis_tvalid=1, and increment the beat counter.
  - The output register clears m_axis_tvalid when m_axis_tready is high and no new beat is accepted in the same cycle.
  - This gives full throughput: one beat per cycle while the source and sink both stream.
- Release from LOCKED:
  - Release occurs when the accepted beat has tlast=1, or when MAX_BEATS != 0 and the beat counter reaches MAX_BEATS.
  - On release: last<=grant, counter<=0, state<=IDLE.
  - A forced release does not assert m_axis_tlast. The output reflects the source tlast only. The downstream block sees m_axis_tid change.
- Re-arbitration:
  - Next grant is decided in IDLE, one cycle after release. This gives a 1-cycle bubble per packet boundary.
  - A port that was just released loses priority to every other valid port.
  - The same port is re-granted only if it is the sole requester.
- Latency: s_axis_tvalid rising in IDLE at cycle 0 → tready asserted in cycle 1 → m_axis_tvalid in cycle 2.
- Source tvalid dropping in LOCKED: the grant is held; tvalid deassertion mid-packet does not release the grant.
- Downstream stall: m_axis_tvalid & ~m_axis_tready holds the output register stable and forces tready[grant]=0.
- Other port behaviour: non-granted tvalid is ignored. No data is ever lost or duplicated.
- Status outputs: sts_busy = (state==LOCKED). sts_grant is registered with the grant and holds its value in IDLE.
- Beat counter: 16 bits. It saturates at MAX_BEATS and is unused when MAX_BEATS=0.
- Reset mid-packet: all outputs go to their reset values immediately. A partial packet is dropped and is not resumed.

Test Plan:
- Single requester: port 2 sends 3 beats 0xA0, 0xA1, 0xA2 (last on beat 3), sink always ready → m_axis beats identical with tid=2, tlast on the third beat, first m_axis_tvalid 2 cycles after s_axis_tvalid, sts_busy high for 3 cycles.
- Round-robin fairness: ports 0, 1 and 3 each continuously offer 2-beat packets → grant order 0,1,3,0,1,3; exactly one idle cycle between packets; port 2 never granted.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet on port 1 → output data stable while stalled, s_axis_tready[1]=0 during the stall cycles, all 4 beats delivered in order with no duplicates.
- Forced release: MAX_BEATS=4; port 0 sends a 10-beat packet while port 1 is pending → port 0 beats 0-3, then port 1's packet, then port 0 resumes beats 4-7; m_axis_tlast low on the forced boundary.
- Source gap: port 3 deasserts tvalid for 5 cycles mid-packet while port 0 requests → grant stays 3, port 0 tready stays 0 until port 3's tlast.
- Async reset: assert aresetn=0 mid-packet, between clock edges → m_axis_tvalid, s_axis_tready and sts_busy drop without waiting for an edge; after release, port 0 has first priority.

Source files
------------

// File: rtl/axis_rr_write_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_write_arbiter
//
// Shares one AXI4-Stream write path among NUM_PORTS stream requesters.
// A round-robin arbiter picks one requester and locks onto it. The lock is
// released when that port delivers tlast, or when MAX_BEATS beats have been
// accepted (MAX_BEATS = 0 disables this limit). Accepted beats pass through
// a single registered output stage. The stage carries the source port index
// on m_axis_tid.
//
// Each new grant costs one arbitration cycle in IDLE. This gives a one-cycle
// bubble at every packet or forced-release boundary. Beats inside a grant
// stream at full rate.
//
// Ports
//   aclk            in   clock
//   aresetn         in   asynchronous active-low reset
//   s_axis_tdata    in   NUM_PORTS*AXIS_TDATA_WIDTH, port k at [k*W +: W]
//   s_axis_tvalid   in   NUM_PORTS, per-port valid
//   s_axis_tlast    in   NUM_PORTS, per-port end of packet
//   s_axis_tready   out  NUM_PORTS, one-hot (granted port) or zero
//   m_axis_tdata    out  AXIS_TDATA_WIDTH, registered output data
//   m_axis_tid      out  ID_WIDTH, source port of the output beat
//   m_axis_tlast    out  source tlast of the output beat (never forced)
//   m_axis_tvalid   out  output valid
//   m_axis_tready   in   downstream ready
//   sts_busy        out  high while a grant is held
//   sts_grant       out  ID_WIDTH, current or most recent grant
// -----------------------------------------------------------------------------
module axis_rr_write_arbiter #(
    parameter int NUM_PORTS        = 4,
    parameter int ID_WIDTH         = 2,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MAX_BEATS        = 0
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
    output logic [NUM_PORTS-1:0]                  s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
    output logic [ID_WIDTH-1:0]                   m_axis_tid,
    output logic                                  m_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  sts_busy,
    output logic [ID_WIDTH-1:0]                   sts_grant
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_LOCKED  = 1'b1;

    localparam logic [15:0] BEAT_LIMIT = 16'(MAX_BEATS);
    localparam bit          LIMIT_EN   = (MAX_BEATS != 0);

    logic [0:0]                  state;
    logic [ID_WIDTH-1:0]         grant;
    logic [ID_WIDTH-1:0]         last_ptr;
    logic [15:0]                 beat_cnt;

    logic                        arb_found;
    logic [ID_WIDTH-1:0]         arb_sel;

    logic                        sel_valid;
    logic                        sel_last;
    logic [AXIS_TDATA_WIDTH-1:0] sel_data;

    logic                        out_space;
    logic                        beat_accept;
    logic                        limit_hit;
    logic                        grant_done;

    // -------------------------------------------------------------------------
    // Round-robin search. The first valid port after last_ptr wins. The port
    // served last is visited last, so it wins again only when it is the sole
    // requester. The nested loop keeps every select index constant.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!arb_found && s_axis_tvalid[p] &&
                    (p == (int'(last_ptr) + i) % NUM_PORTS)) begin
                    arb_found = 1'b1;
                    arb_sel   = ID_WIDTH'(p);
                end
            end
        end
    end

    // Mux the granted port's stream onto the internal select bus.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(grant) == p) begin
                sel_valid = s_axis_tvalid[p];
                sel_last  = s_axis_tlast[p];
                sel_data  = s_axis_tdata[p*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
            end
        end
    end

    // The output register can take a beat when it is empty or when it drains
    // in this cycle.
    assign out_space = ~m_axis_tvalid | m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            s_axis_tready[p] = (state == ST_LOCKED) && (int'(grant) == p) && out_space;
        end
    end

    assign beat_accept = (state == ST_LOCKED) && sel_valid && out_space;

    // The counter shows beats already taken. The beat being accepted now is
    // the MAX_BEATS-th beat when the counter equals MAX_BEATS-1.
    assign limit_hit   = LIMIT_EN && (beat_cnt == BEAT_LIMIT - 16'd1);
    assign grant_done  = beat_accept && (sel_last || limit_hit);

    // -------------------------------------------------------------------------
    // Grant FSM. The pointer resets to NUM_PORTS-1, so port 0 is searched
    // first after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            grant    <= '0;
            last_ptr <= ID_WIDTH'(NUM_PORTS - 1);
            beat_cnt <= '0;
        end else begin
            // NOTE: state registers are written with non-blocking assignments.
            // Every block triggered on this edge then reads pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant <= arb_sel;
                        state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (grant_done) begin
                        last_ptr <= grant;
                        beat_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (beat_accept && LIMIT_EN && (beat_cnt != BEAT_LIMIT)) begin
                        beat_cnt <= beat_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output register. A new beat overwrites the register only when it has
    // space. Under a stall the register holds its value because s_axis_tready
    // is low at the same time. m_axis_tlast follows the source tlast only, so
    // a forced release shows downstream only as a change of m_axis_tid.
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (beat_accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tid    <= grant;
            m_axis_tlast  <= sel_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign sts_busy  = (state == ST_LOCKED);
    assign sts_grant = grant;

endmodule

// File: tb/tb_axis_rr_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_write_arbiter
//
// Per-port source queues feed the DUT. A beat queue entry can be a data beat
// or an idle slot, which holds tvalid low for one cycle. Expected output
// beats are pushed to a scoreboard queue in the order that round-robin with
// packet locking must deliver them. A negedge monitor pops the scoreboard
// and also checks the ready and stall rules.
// -----------------------------------------------------------------------------
module tb_axis_rr_write_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int MB = 4;

    typedef struct packed { logic [W-1:0] data; logic [IW-1:0] id; logic last; } exp_t;
    typedef struct packed { logic idle; logic last; logic [W-1:0] data; } src_t;
    typedef struct { int cyc; logic [IW-1:0] id; logic last; } log_t;

    logic              aclk;
    logic              aresetn;
    logic [NP*W-1:0]   s_axis_tdata;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [W-1:0]      m_axis_tdata;
    logic [IW-1:0]     m_axis_tid;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              sts_busy;
    logic [IW-1:0]     sts_grant;

    axis_rr_write_arbiter #(
        .NUM_PORTS(NP), .ID_WIDTH(IW), .AXIS_TDATA_WIDTH(W), .MAX_BEATS(MB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .sts_busy(sts_busy), .sts_grant(sts_grant)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t          exp_q[$];
    src_t          src_q[NP][$];
    log_t          out_log[$];
    logic [NP-1:0] src_fire = '0;
    logic [NP-1:0] shown_idle = '0;
    logic          prev_stall = 1'b0;
    exp_t          prev_out;
    int            busy_cycles = 0;
    int            stall_cycles = 0;
    bit            lat_arm = 0;
    int            sv_cyc = -1;
    int            mv_cyc = -1;
    logic [3:0]    pat = 4'b1001;   // m_axis_tready sequence 1,0,0,1

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // ---------------- source driver ----------------
    initial begin
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        forever begin
            @(posedge aclk);
            #1;
            for (int k = 0; k < NP; k++) begin
                if (src_q[k].size() > 0 && (src_fire[k] || shown_idle[k]))
                    void'(src_q[k].pop_front());
                shown_idle[k] = 1'b0;
                if (src_q[k].size() > 0 && src_q[k][0].idle) begin
                    s_axis_tvalid[k] = 1'b0;
                    s_axis_tlast[k]  = 1'b0;
                    shown_idle[k]    = 1'b1;
                end else if (src_q[k].size() > 0) begin
                    s_axis_tvalid[k]         = 1'b1;
                    s_axis_tlast[k]          = src_q[k][0].last;
                    s_axis_tdata[k*W +: W]   = src_q[k][0].data;
                end else begin
                    s_axis_tvalid[k] = 1'b0;
                    s_axis_tlast[k]  = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [NP-1:0] gmask;
        exp_t got;
        exp_t e;
        forever begin
            @(negedge aclk);
            src_fire = s_axis_tvalid & s_axis_tready;
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                gmask = 4'b0001 << sts_grant;
                if (sts_busy) busy_cycles++;
                if (lat_arm && sv_cyc < 0 && (|s_axis_tvalid)) sv_cyc = cyc;
                if (lat_arm && mv_cyc < 0 && m_axis_tvalid) mv_cyc = cyc;

                checks++;
                if (sts_busy ? ((s_axis_tready & ~gmask) != '0) : (s_axis_tready != '0)) begin
                    $display("FAIL ready_select: s_axis_tready=%b busy=%0b grant=%0d, required zero or only the granted bit",
                             s_axis_tready, sts_busy, sts_grant);
                    errors++;
                end

                got = {m_axis_tdata, m_axis_tid, m_axis_tlast};
                if (prev_stall) begin
                    checks++;
                    if (!m_axis_tvalid || got !== prev_out) begin
                        $display("FAIL stall_hold: output valid=%0b beat=%h, required valid=1 beat=%h",
                                 m_axis_tvalid, got, prev_out);
                        errors++;
                    end
                end
                if (m_axis_tvalid && !m_axis_tready) begin
                    stall_cycles++;
                    checks++;
                    if (s_axis_tready !== '0) begin
                        $display("FAIL stall_ready: s_axis_tready=%b during stall, required 0000", s_axis_tready);
                        errors++;
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_out   = got;

                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_extra: unexpected beat data=%h tid=%0d last=%0b, required none",
                                 m_axis_tdata, m_axis_tid, m_axis_tlast);
                        errors++;
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            $display("FAIL sb_beat: data=%h tid=%0d last=%0b, required data=%h tid=%0d last=%0b",
                                     m_axis_tdata, m_axis_tid, m_axis_tlast, e.data, e.id, e.last);
                            errors++;
                        end
                    end
                    out_log.push_back('{cyc, m_axis_tid, m_axis_tlast});
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic bit all_src_empty();
        for (int k = 0; k < NP; k++)
            if (src_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_tb_state();
        for (int k = 0; k < NP; k++) src_q[k].delete();
        exp_q.delete();
        src_fire   = '0;
        shown_idle = '0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        clear_tb_state();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic send_pkt(input int port, input logic [W-1:0] base, input int n);
        for (int b = 0; b < n; b++)
            src_q[port].push_back('{1'b0, (b == n - 1), base + W'(b)});
    endtask

    task automatic send_idle(input int port, input int n);
        for (int b = 0; b < n; b++)
            src_q[port].push_back('{1'b1, 1'b0, '0});
    endtask

    task automatic expect_pkt(input int port, input logic [W-1:0] base, input int first,
                              input int n, input bit last_at_end);
        for (int b = first; b < first + n; b++)
            exp_q.push_back('{base + W'(b), IW'(port), last_at_end && (b == first + n - 1)});
    endtask

    task automatic wait_drain(input string name, input int budget, input bit use_pat);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(posedge aclk);
            #2;
            if (use_pat) m_axis_tready = pat[3 - (n % 4)];
            n++;
            done = (exp_q.size() == 0) && all_src_empty() && !m_axis_tvalid && !sts_busy;
        end
        checks++;
        if (!done) begin
            $display("FAIL %s_drain: %0d expected beats outstanding after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            errors++;
        end
        m_axis_tready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        clear_tb_state();
        send_pkt(1, 32'h0000_0055, 1);
        repeat (3) @(posedge aclk);
        #2;
        checks++;
        if (s_axis_tready !== '0) begin
            $display("FAIL rst_tready: %b, required 0000", s_axis_tready); errors++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            $display("FAIL rst_mvalid_mlast: valid=%0b last=%0b, required 0 0", m_axis_tvalid, m_axis_tlast); errors++;
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tid !== '0) begin
            $display("FAIL rst_mdata: data=%h tid=%0d, required 0 0", m_axis_tdata, m_axis_tid); errors++;
        end
        checks++;
        if (sts_busy !== 1'b0 || sts_grant !== '0) begin
            $display("FAIL rst_status: busy=%0b grant=%0d, required 0 0", sts_busy, sts_grant); errors++;
        end
        expect_pkt(1, 32'h0000_0055, 0, 1, 1'b1);
        @(negedge aclk);
        aresetn = 1'b1;
        wait_drain("reset", 40, 1'b0);
    endtask

    task automatic test_single();
        do_reset();
        busy_cycles = 0;
        sv_cyc      = -1;
        mv_cyc      = -1;
        lat_arm     = 1;
        send_pkt(2, 32'h0000_00A0, 3);
        expect_pkt(2, 32'h0000_00A0, 0, 3, 1'b1);
        wait_drain("single", 50, 1'b0);
        lat_arm = 0;
        checks++;
        if (sv_cyc < 0 || mv_cyc - sv_cyc != 2) begin
            $display("FAIL single_latency: %0d cycles, required 2", mv_cyc - sv_cyc); errors++;
        end
        checks++;
        if (busy_cycles != 3) begin
            $display("FAIL single_busy: %0d cycles, required 3", busy_cycles); errors++;
        end
        checks++;
        if (sts_grant !== 2'd2) begin
            $display("FAIL single_grant_hold: %0d, required 2", sts_grant); errors++;
        end
    endtask

    task automatic test_round_robin();
        int start;
        do_reset();
        start = out_log.size();
        for (int k = 0; k < 2; k++) begin
            send_pkt(0, 32'h00C0_0000 + 32'(k * 16), 2);
            send_pkt(1, 32'h00C0_0100 + 32'(k * 16), 2);
            send_pkt(3, 32'h00C0_0300 + 32'(k * 16), 2);
        end
        for (int k = 0; k < 2; k++) begin
            expect_pkt(0, 32'h00C0_0000 + 32'(k * 16), 0, 2, 1'b1);
            expect_pkt(1, 32'h00C0_0100 + 32'(k * 16), 0, 2, 1'b1);
            expect_pkt(3, 32'h00C0_0300 + 32'(k * 16), 0, 2, 1'b1);
        end
        wait_drain("rr", 100, 1'b0);
        checks++;
        if (out_log.size() - start != 12) begin
            $display("FAIL rr_count: %0d beats, required 12", out_log.size() - start); errors++;
        end
        for (int i = start + 1; i < out_log.size(); i++) begin
            checks++;
            if (out_log[i].cyc - out_log[i-1].cyc != (out_log[i-1].last ? 2 : 1)) begin
                $display("FAIL rr_spacing: beat %0d gap %0d cycles, required %0d",
                         i - start, out_log[i].cyc - out_log[i-1].cyc, out_log[i-1].last ? 2 : 1);
                errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        stall_cycles = 0;
        send_pkt(1, 32'h0000_00D0, 4);
        expect_pkt(1, 32'h0000_00D0, 0, 4, 1'b1);
        wait_drain("backpressure", 80, 1'b1);
        checks++;
        if (stall_cycles == 0) begin
            $display("FAIL bp_stalls: %0d stall cycles seen, required at least 1", stall_cycles); errors++;
        end
    endtask

    task automatic test_forced_release();
        do_reset();
        send_pkt(0, 32'h0000_0A00, 10);
        send_pkt(1, 32'h0000_0B00, 2);
        expect_pkt(0, 32'h0000_0A00, 0, 4, 1'b0);
        expect_pkt(1, 32'h0000_0B00, 0, 2, 1'b1);
        expect_pkt(0, 32'h0000_0A00, 4, 4, 1'b0);
        expect_pkt(0, 32'h0000_0A00, 8, 2, 1'b1);
        wait_drain("forced", 120, 1'b0);
    endtask

    task automatic test_source_gap();
        int  n;
        int  gap;
        bit  done;
        do_reset();
        send_pkt(3, 32'h0000_00E0, 2);
        src_q[3][1].last = 1'b0;
        send_idle(3, 5);
        src_q[3].push_back('{1'b0, 1'b0, 32'h0000_00E2});
        src_q[3].push_back('{1'b0, 1'b1, 32'h0000_00E3});
        expect_pkt(3, 32'h0000_00E0, 0, 4, 1'b1);
        n = 0;
        while (!sts_busy && n < 20) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (sts_grant !== 2'd3 || sts_busy !== 1'b1) begin
            $display("FAIL gap_first_grant: busy=%0b grant=%0d, required 1 3", sts_busy, sts_grant); errors++;
        end
        send_pkt(0, 32'h0000_00F0, 1);
        expect_pkt(0, 32'h0000_00F0, 0, 1, 1'b1);
        n    = 0;
        gap  = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge aclk);
            n++;
            checks++;
            if (sts_grant !== 2'd3 || sts_busy !== 1'b1 || s_axis_tready[0] !== 1'b0) begin
                $display("FAIL gap_hold: busy=%0b grant=%0d tready0=%0b, required 1 3 0",
                         sts_busy, sts_grant, s_axis_tready[0]);
                errors++;
            end
            if (!s_axis_tvalid[3]) gap++;
            done = s_axis_tvalid[3] && s_axis_tready[3] && s_axis_tlast[3];
        end
        checks++;
        if (!done || gap != 5) begin
            $display("FAIL gap_cycles: done=%0b idle=%0d, required 1 5", done, gap); errors++;
        end
        wait_drain("gap", 60, 1'b0);
    endtask

    task automatic test_async_reset();
        int n;
        int base;
        do_reset();
        send_pkt(0, 32'h0000_0100, 1);
        expect_pkt(0, 32'h0000_0100, 0, 1, 1'b1);
        wait_drain("arst_pre", 40, 1'b0);
        base = out_log.size();
        send_pkt(2, 32'h0000_0200, 4);
        expect_pkt(2, 32'h0000_0200, 0, 4, 1'b1);
        n = 0;
        while (out_log.size() < base + 2 && n < 40) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || sts_busy !== 1'b1) begin
            $display("FAIL arst_midpkt: valid=%0b busy=%0b, required 1 1", m_axis_tvalid, sts_busy); errors++;
        end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || sts_busy !== 1'b0) begin
            $display("FAIL arst_drop: valid=%0b tready=%b busy=%0b, required 0 0000 0",
                     m_axis_tvalid, s_axis_tready, sts_busy);
            errors++;
        end
        checks++;
        if (m_axis_tdata !== '0 || sts_grant !== '0) begin
            $display("FAIL arst_regs: data=%h grant=%0d, required 0 0", m_axis_tdata, sts_grant); errors++;
        end
        clear_tb_state();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        send_pkt(3, 32'h0000_0300, 1);
        send_pkt(0, 32'h0000_0400, 1);
        expect_pkt(0, 32'h0000_0400, 0, 1, 1'b1);
        expect_pkt(3, 32'h0000_0300, 0, 1, 1'b1);
        wait_drain("arst_post", 40, 1'b0);
    endtask

    initial begin
        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_forced_release();
        test_source_gap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
